// File: rtl/shifter_pkg.sv
// Shared definitions for the datapath shifters: controller state type, default
// operand width and the per-stage shift amount used to wire power-of-two stages.
package shifter_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int stage_amount(input int k);
      return 1 << k;
   endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One power-of-two right-shift stage: when enabled, shifts by AMOUNT and fills
// the vacated top bits with the supplied fill bit; otherwise passes data through.
module right_shift_stage #(
   parameter int WIDTH  = 32,
   parameter int AMOUNT = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             fill,
   input  logic             en,
   output logic [WIDTH-1:0] out
);

   assign out = en ? {{AMOUNT{fill}}, data[WIDTH-1:AMOUNT]} : data;

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: one power-of-two stage per clock, MSB stage first.
// Arithmetic fill is compiled in only when SEQ_RIGHT_SHIFTER_ARITH_EN is defined.
module seq_right_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic                     in_arith,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [1:0]               dbg_state
);

   localparam int SHAMT_W = $clog2(WIDTH);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready/valid here come from state only, never from the peer.
   state_e               state_q;
   logic [WIDTH-1:0]     work_q;
   logic [WIDTH-1:0]     work_d;
   logic [SHAMT_W-1:0]   shamt_q;
   logic [SHAMT_W-1:0]   k_q;
   logic [WIDTH-1:0]     out_data_q;
   logic                 fill;
   logic [WIDTH-1:0]     stage_out [SHAMT_W];

`ifdef SEQ_RIGHT_SHIFTER_ARITH_EN
   logic fill_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         fill_q <= in_arith & in_data[WIDTH-1];
      end
   end

   assign fill = fill_q;
`else
   logic unused_arith;

   assign unused_arith = in_arith;
   assign fill         = 1'b0;
`endif

   for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
      right_shift_stage #(
         .WIDTH  (WIDTH),
         .AMOUNT (stage_amount(i))
      ) u_stage (
         .data (work_q),
         .fill (fill),
         .en   (shamt_q[i]),
         .out  (stage_out[i])
      );
   end

   always_comb begin
      work_d = work_q;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (k_q == SHAMT_W'(i)) work_d = stage_out[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         work_q     <= '0;
         shamt_q    <= '0;
         k_q        <= '0;
         out_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q  <= in_data;
                  shamt_q <= in_shamt;
                  k_q     <= SHAMT_W'(SHAMT_W - 1);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               work_q <= work_d;
               if (k_q == '0) begin
                  out_data_q <= work_d;
                  state_q    <= DONE;
               end else begin
                  k_q <= k_q - SHAMT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed and randomized checks of seq_right_shifter against a plain
// arithmetic shift model, with latency, backpressure, busy and reset cases.
module tb_seq_right_shifter;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp;

   seq_right_shifter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .dbg_state (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic a);
`ifdef SEQ_RIGHT_SHIFTER_ARITH_EN
      if (a) return 32'($signed(d) >>> s);
`endif
      return d >> s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits for in_ready, presents one request, returns at the negedge after accept.
   task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(model(d, int'(s), a));
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_arith = a;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      in_arith = 1'($urandom_range(0, 1));
      check("busy_in_ready", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic wait_result(input int pre);
      int lat = pre;
      while (!out_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check("latency", lat, 32'd5);
      last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      check("out_data", out_data, last_exp);
   endtask

   task automatic release_out(input int hold, input logic pre);
      if (!pre) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, last_exp);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
      check("post_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_arith  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      send(32'h8000_0000, 5'd31, 1'b0);
      wait_result(0);
      check("logical_31", last_exp, 32'h0000_0001);
      release_out(0, 1'b0);

      send(32'h8000_0000, 5'd4, 1'b1);
      wait_result(0);
`ifdef SEQ_RIGHT_SHIFTER_ARITH_EN
      check("arith_4", last_exp, 32'hF800_0000);
`else
      check("arith_off_4", last_exp, 32'h0800_0000);
`endif
      release_out(0, 1'b0);

      send(32'hDEAD_BEEF, 5'd0, 1'b0);
      wait_result(0);
      release_out(0, 1'b0);

      // Backpressure for 10 cycles
      send(32'h1234_5678, 5'd16, 1'b0);
      wait_result(0);
      check("half_word", last_exp, 32'h0000_1234);
      release_out(10, 1'b0);

      // Request offered while busy must be dropped
      send(32'h1234_5678, 5'd16, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      in_shamt = 5'd8;
      in_arith = 1'b0;
      @(negedge clock);
      check("busy_ignore_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
      in_valid = 1'b0;
      wait_result(2);
      release_out(0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check("not_captured", {31'd0, out_valid}, 32'd0);
      end

      // Consumer already ready when the result appears
      out_ready = 1'b1;
      send(32'hF0F0_1234, 5'd7, 1'b1);
      out_ready = 1'b1;
      wait_result(0);
      release_out(0, 1'b1);

      // Abort in the middle of the shift sequence
      send(32'hCAFE_F00D, 5'd12, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_out_data", out_data, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      void'(exp_q.pop_front());
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("after_abort_ready", {31'd0, in_ready}, 32'd1);
      send(32'h0000_0100, 5'd8, 1'b0);
      wait_result(0);
      check("after_abort_val", last_exp, 32'h0000_0001);
      release_out(0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         logic pre;
         pre = 1'($urandom_range(0, 1));
         out_ready = pre;
         send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         out_ready = pre;
         wait_result(0);
         release_out($urandom_range(0, 3), pre);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_right_shifter.md
# seq_right_shifter

Multi-cycle 32-bit right shifter for the datapath ALU: the right-shift counterpart to the fixed left-shift stages. It accepts an operand and shift amount over a valid/ready handshake and decomposes the shift into power-of-two stages (16, 8, 4, 2, 1), applying one stage per clock. It supports logical and, when compiled in, arithmetic right shift. It sits beside the barrel left shifter and feeds the ALU result mux through the same handshake.

## Interface
- WIDTH, 32, operand width; must be a power of two ≥ 2; SHAMT_W = log2(WIDTH) is a localparam (5 at default)
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request; high only in IDLE
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result, registered

## Operation
- States: IDLE, SHIFT, DONE; reset enters IDLE.
- IDLE: in_ready=1. On in_valid: latch in_data into work reg, latch in_shamt, latch fill bit (in_data[WIDTH-1] if arith else 0), set stage index k=SHAMT_W-1, go to SHIFT.
- SHIFT: each cycle, if shamt[k]=1 then work = work >> 2^k with top 2^k bits = fill bit; else unchanged. When k=0, go to DONE; otherwise decrement k.
- All SHAMT_W stages always execute, including zero bits and shamt=0, which gives fixed latency.
- DONE: out_valid=1 and out_data=work. Hold both stable until out_ready=1, then go to IDLE.
- in_valid while not in IDLE is ignored; the request is not captured. Upstream must hold in_valid until in_ready.
- No same-cycle DONE→accept: a new request is taken only in IDLE.
- Inputs are sampled only in the accept cycle. Later changes to in_* have no effect on the operation in flight.

## Timing
- Reset (async assert): state=IDLE, out_valid=0, out_data=0, in_ready=1, work/shamt/fill/k=0.
- Reset deassertion is synchronized externally. The block acts on the first rising edge after deassert.
- Accept at edge E0. Stages run at edges E1..E5. out_valid goes high after E5, giving 5 cycles accept→valid at WIDTH=32 (SHAMT_W in general).
- If out_ready is already high when out_valid rises, the handshake completes at edge E6, and in_ready rises after E6.
- Minimum request interval: SHAMT_W+2 cycles.
- Reset mid-SHIFT or mid-DONE aborts immediately. out_valid drops asynchronously and the result is discarded.
- in_ready and out_valid are decoded from state only; there is no combinational path from in_valid or out_ready.

## Configuration
- SEQ_RIGHT_SHIFTER_ARITH_EN defined: in_arith is honored and the fill bit is the latched operand MSB when in_arith=1.
- Macro undefined: in_arith is ignored, the fill bit is tied to 0, no fill register is synthesized, and all shifts are logical.

## Structure
- Shared package shifter_pkg holds:
  - the state enum type (IDLE, SHIFT, DONE)
  - localparam DEFAULT_WIDTH=32
  - a function returning stage amount 2^k, also used by the left shifter's stage wiring
- One natural sub-module: right_shift_stage, which is combinational. Its parameters are WIDTH and AMOUNT; its ports are data, fill, en, out. The main block instantiates it via a mux indexed by k, or as SHAMT_W instances with the k-th enable selected.

## Test plan
- Logical: in_data=0x80000000, shamt=31, arith=0 → out_data=0x00000001; out_valid rises exactly 5 cycles after accept.
- Arithmetic (macro defined): 0x80000000, shamt=4, arith=1 → 0xF8000000. With the macro undefined, the same stimulus → 0x08000000.
- Zero shift: 0xDEADBEEF, shamt=0 → 0xDEADBEEF with the same 5-cycle latency. Also 0x12345678, shamt=16 → 0x00001234.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and out_data stable, in_ready=0. Release → in_ready=1 on the next cycle.
- Busy ignore: pulse in_valid with 0xFFFFFFFF/shamt=8 during SHIFT → first result unaffected, second request not captured.
- Reset mid-SHIFT: assert reset_n=0 at stage 2 → out_valid=0 and out_data=0 immediately. After release, in_ready=1 and a fresh request 0x00000100 >> 8 = 0x00000001 completes normally.
